// File: rtl/mcml_pkg.sv
// Shared definitions for the photon pipeline control blocks.
package mcml_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam int PIPE_DEPTH_DEF  = 37;
    localparam int COUNT_WIDTH_DEF = 32;
endpackage

// File: rtl/slot_occupancy_ring.sv
// Occupancy shadow of the photon ring: one bit per slot, shifted with the pipeline.
import mcml_pkg::*;

module slot_occupancy_ring #(
    parameter int DEPTH = PIPE_DEPTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic head,
    output logic tail,
    output logic empty_next
);
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] occ_next;

    always_comb begin
        occ_next = occ;
        if (clear)
            occ_next = '0;
        else if (enable)
            occ_next = {occ[DEPTH-2:0], head};
    end

    always_ff @(posedge clock) begin
        if (reset)
            occ <= '0;
        else
            occ <= occ_next;
    end

    assign tail = occ[DEPTH-1];
    // Looks at the value being loaded so the drain can end on the cycle the last photon retires.
    assign empty_next = ~|occ_next;
endmodule

// File: rtl/photon_scheduler.sv
// Recirculating photon pipeline sequencer: enable, head-mux select and launch/retire counting.
import mcml_pkg::*;

module photon_scheduler #(
    parameter int PIPE_DEPTH  = PIPE_DEPTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] total_photons,
    input  logic                   tail_dead,
    input  logic                   init_valid,
    output logic                   init_ready,
    output logic                   inject,
    output logic                   pipe_enable,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] launched_count,
    output logic [COUNT_WIDTH-1:0] retired_count
);
    sched_state_t state, state_next;

    logic [COUNT_WIDTH-1:0] total;
    logic [COUNT_WIDTH-1:0] launched;
    logic [COUNT_WIDTH-1:0] retired;
    logic [COUNT_WIDTH-1:0] launched_inc;

    logic occ_tail;
    logic slot_free;
    logic retire;
    logic retire_fire;
    logic head;
    logic accept_start;
    logic ring_empty_next;

    assign slot_free    = ~occ_tail | tail_dead;
    assign retire       = occ_tail & tail_dead;
    assign retire_fire  = pipe_enable & retire;
    assign head         = inject | (occ_tail & ~tail_dead);
    assign accept_start = (state == ST_IDLE) & start;
    assign launched_inc = launched + COUNT_WIDTH'(1);

    slot_occupancy_ring #(
        .DEPTH (PIPE_DEPTH)
    ) u_ring (
        .clock      (clock),
        .reset      (reset),
        .clear      (accept_start),
        .enable     (pipe_enable),
        .head       (head),
        .tail       (occ_tail),
        .empty_next (ring_empty_next)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (total_photons == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (init_ready && launched_inc == total) state_next = ST_DRAIN;
            ST_DRAIN: if (ring_empty_next) state_next = ST_DONE;
            ST_DONE:  if (!start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        init_ready     = 1'b0;
        inject         = 1'b0;
        pipe_enable    = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        launched_count = launched;
        retired_count  = retired;
        case (state)
            ST_IDLE: begin
                launched_count = '0;
                retired_count  = '0;
            end
            ST_RUN: begin
                busy = 1'b1;
                // A free slot with nothing to inject stalls the whole ring.
                if (!slot_free) begin
                    pipe_enable = 1'b1;
                end else if (init_valid) begin
                    pipe_enable = 1'b1;
                    inject      = 1'b1;
                    init_ready  = 1'b1;
                end
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                pipe_enable = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            total    <= '0;
            launched <= '0;
            retired  <= '0;
        end else if (accept_start) begin
            total    <= total_photons;
            launched <= '0;
            retired  <= '0;
        end else begin
            if (init_ready)
                launched <= launched_inc;
            if (retire_fire)
                retired <= retired + COUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_photon_scheduler.sv
// Directed vector bench for photon_scheduler with a 4-slot ring.
module tb_photon_scheduler;
    localparam int PD = 4;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] total_photons;
    logic          tail_dead;
    logic          init_valid;
    logic          init_ready, inject, pipe_enable, busy, done;
    logic [CW-1:0] launched_count, retired_count;

    int checks = 0;
    int failures = 0;

    photon_scheduler #(.PIPE_DEPTH(PD), .COUNT_WIDTH(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .total_photons  (total_photons),
        .tail_dead      (tail_dead),
        .init_valid     (init_valid),
        .init_ready     (init_ready),
        .inject         (inject),
        .pipe_enable    (pipe_enable),
        .busy           (busy),
        .done           (done),
        .launched_count (launched_count),
        .retired_count  (retired_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          start;
        logic [CW-1:0] tot;
        logic          td;
        logic          iv;
        logic          ir;
        logic          inj;
        logic          pe;
        logic          busy;
        logic          done;
        logic [CW-1:0] l;
        logic [CW-1:0] r;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input int t, input logic td, input logic iv,
                       input logic ir, input logic inj, input logic pe, input logic b,
                       input logic d, input int l, input int r);
        vec_t v;
        v.start = s; v.tot = CW'(t); v.td = td; v.iv = iv;
        v.ir = ir; v.inj = inj; v.pe = pe; v.busy = b; v.done = d;
        v.l = CW'(l); v.r = CW'(r);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0d want=%0d", nm, row, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_init_ready"}, -1, int'(init_ready), 0);
        chk({nm, "_inject"}, -1, int'(inject), 0);
        chk({nm, "_pipe_enable"}, -1, int'(pipe_enable), 0);
        chk({nm, "_busy"}, -1, int'(busy), 0);
        chk({nm, "_done"}, -1, int'(done), 0);
        chk({nm, "_launched"}, -1, int'(launched_count), 0);
        chk({nm, "_retired"}, -1, int'(retired_count), 0);
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; total_photons = '0; tail_dead = 1'b1; init_valid = 1'b1;
        repeat (2) @(negedge clock);
        #1 chk_idle("reset");
        reset = 1'b0;

        // Run of 3 with every occupied tail dead: injects on cycles 1-3, done on cycle 8.
        add(1,3,0,1, 0,0,0,0,0, 0,0);
        add(0,3,0,1, 1,1,1,1,0, 0,0);
        add(0,3,0,1, 1,1,1,1,0, 1,0);
        add(0,3,0,1, 1,1,1,1,0, 2,0);
        add(0,3,0,1, 0,0,1,1,0, 3,0);
        add(0,3,1,1, 0,0,1,1,0, 3,0);
        add(0,3,1,1, 0,0,1,1,0, 3,1);
        add(0,3,1,1, 0,0,1,1,0, 3,2);
        add(0,3,1,1, 0,0,0,0,1, 3,3);
        add(0,3,0,0, 0,0,0,0,0, 0,0);
        // Run of 5: 5-cycle stall (start ignored while busy), fill, live recirculation,
        // simultaneous retire+inject, drain, start held through DONE.
        add(1,5,0,0, 0,0,0,0,0, 0,0);
        add(0,5,1,0, 0,0,0,1,0, 0,0);
        add(1,5,1,0, 0,0,0,1,0, 0,0);
        add(1,5,1,0, 0,0,0,1,0, 0,0);
        add(0,5,1,0, 0,0,0,1,0, 0,0);
        add(0,5,1,0, 0,0,0,1,0, 0,0);
        add(0,5,0,1, 1,1,1,1,0, 0,0);
        add(0,5,0,1, 1,1,1,1,0, 1,0);
        add(0,5,0,1, 1,1,1,1,0, 2,0);
        add(0,5,0,1, 1,1,1,1,0, 3,0);
        add(0,5,0,1, 0,0,1,1,0, 4,0);
        add(0,5,1,1, 1,1,1,1,0, 4,0);
        add(1,5,0,1, 0,0,1,1,0, 5,1);
        add(0,5,1,0, 0,0,1,1,0, 5,1);
        add(0,5,1,0, 0,0,1,1,0, 5,2);
        add(0,5,1,0, 0,0,1,1,0, 5,3);
        add(0,5,1,0, 0,0,1,1,0, 5,4);
        add(1,5,0,0, 0,0,0,0,1, 5,5);
        add(1,5,0,0, 0,0,0,0,1, 5,5);
        add(0,5,0,0, 0,0,0,0,1, 5,5);
        add(0,5,0,0, 0,0,0,0,0, 0,0);
        // Zero-photon request goes straight to DONE.
        add(1,0,0,1, 0,0,0,0,0, 0,0);
        add(0,0,0,1, 0,0,0,0,1, 0,0);
        add(0,0,0,1, 0,0,0,0,0, 0,0);

        foreach (vq[i]) begin
            @(negedge clock);
            start = vq[i].start; total_photons = vq[i].tot;
            tail_dead = vq[i].td; init_valid = vq[i].iv;
            #1;
            chk("init_ready", i, int'(init_ready), int'(vq[i].ir));
            chk("inject", i, int'(inject), int'(vq[i].inj));
            chk("pipe_enable", i, int'(pipe_enable), int'(vq[i].pe));
            chk("busy", i, int'(busy), int'(vq[i].busy));
            chk("done", i, int'(done), int'(vq[i].done));
            chk("launched", i, int'(launched_count), int'(vq[i].l));
            chk("retired", i, int'(retired_count), int'(vq[i].r));
        end

        // Abort a run after two launches with a synchronous reset.
        @(negedge clock);
        start = 1'b1; total_photons = 8'd4; init_valid = 1'b1; tail_dead = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("abort_launched", -1, int'(launched_count), 2);
        chk("abort_busy", -1, int'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1 chk_idle("post_reset");

        // Fresh single-photon run completes cleanly.
        @(negedge clock);
        start = 1'b1; total_photons = 8'd1; tail_dead = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        #1;
        while (!done && k < 20) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk("rerun_done", k, int'(done), 1);
        chk("rerun_launched", k, int'(launched_count), 1);
        chk("rerun_retired", k, int'(retired_count), 1);
        @(negedge clock);
        #1 chk("rerun_idle_done", -1, int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/photon_scheduler.md
# photon_scheduler

Sequencing controller for the recirculating photon pipeline: the boundary-check, hop, drop and spin stages form a ring of PIPE_DEPTH slots that advances one slot per enabled cycle. The block generates the shared pipeline enable, decides per cycle whether the photon leaving the pipeline tail recirculates or its slot is refilled from the photon initializer, and counts launched and retired photons until the requested total has completed.

## Interface
- PIPE_DEPTH, 37: number of photon slots in the ring, ≥2
- COUNT_WIDTH, 32: width of the photon counters and total
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; sampled only in IDLE
- total_photons  in  COUNT_WIDTH  photons to simulate; latched on accepted start
- tail_dead  in  1  dead flag of the photon at the pipeline tail this cycle
- init_valid  in  1  initializer has a fresh photon ready
- init_ready  out  1  fresh photon consumed this cycle (transfer = init_valid & init_ready)
- inject  out  1  head mux select: 1 = fresh photon, 0 = recirculated tail photon
- pipe_enable  out  1  advance every pipeline stage this cycle
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- launched_count  out  COUNT_WIDTH  photons injected since start
- retired_count  out  COUNT_WIDTH  live photons retired since start

## Operation
- Registered state: FSM {IDLE, RUN, DRAIN, DONE}, occ[PIPE_DEPTH-1:0] (slot holds a launched, not-yet-retired photon), total, launched, retired.
- Outputs are combinational decodes of registered state plus tail_dead/init_valid.
- occ_tail = occ[PIPE_DEPTH-1]; slot_free = ~occ_tail | tail_dead; retire = occ_tail & tail_dead.
- IDLE: all outputs 0. On start: total <= total_photons, counters <= 0, occ <= 0; next RUN, or DONE if total_photons == 0.
- RUN, slot not free: pipe_enable=1, inject=0.
- RUN, slot free: if init_valid: pipe_enable=1, inject=1, init_ready=1, launched++. Else stall: pipe_enable=0, inject=0, init_ready=0; occ, counters unchanged.
- RUN -> DRAIN on the cycle launched becomes total.
- DRAIN: pipe_enable=1, inject=0, init_ready=0 every cycle; free slots recirculate as dead.
- DRAIN -> DONE when the next occ value is all zero.
- DONE: done=1, pipe_enable=0. Returns to IDLE when start=0.
- On every cycle with pipe_enable=1: occ <= {occ[PIPE_DEPTH-2:0], head}, where head = inject | (occ_tail & ~tail_dead). retired += retire.
- When pipe_enable=0, tail_dead is ignored and no retire is counted. A stalled slot is therefore counted exactly once.
- Counters wrap modulo 2^COUNT_WIDTH. retired never exceeds launched by construction.
- start while busy or done is ignored. Only start low, then high again in IDLE, begins a new run.

## Timing
- Reset value of every output and register is 0; FSM resets to IDLE.
- Reset mid-run aborts immediately. Pipeline contents are the datapath's concern: its own reset marks all photons dead.
- Start to first pipe_enable: 1 cycle (IDLE->RUN edge).
- Injection decision has zero latency: init_ready/inject are valid in the same cycle as tail_dead/init_valid.
- An injected photon re-reaches the tail PIPE_DEPTH enabled cycles later.
- Simultaneous retire and inject in one cycle is legal. The slot is reused, and retired and launched both increment.
- DRAIN lasts at most PIPE_DEPTH enabled cycles after the last photon dies.

## Structure
- Shared package mcml_pkg: FSM state encoding, COUNT_WIDTH, PIPE_DEPTH defaults.
- Sub-module slot_occupancy_ring: PIPE_DEPTH-bit shift register.
  - Inputs: enable, head bit, clear.
  - Outputs: tail bit, all-empty flag.
- FSM and counters stay in photon_scheduler.

## Test plan
- total=0, start=1 -> DONE next cycle; pipe_enable never 1; both counts 0.
- total=3, init_valid=1, PIPE_DEPTH=4, tail_dead=1 whenever occupied -> 3 injects on cycles 1–3, DRAIN; retired=3 and done by cycle ≤8.
- Stall: slot free, init_valid=0 for 5 cycles -> pipe_enable=0 for those 5 cycles; occ and counts frozen; injection resumes the cycle init_valid rises.
- Live photon at tail (tail_dead=0) with init_valid=1 -> inject=0, init_ready=0, photon recirculates; retired unchanged.
- Reset asserted in RUN with launched=2 -> next cycle all outputs 0, FSM IDLE; a fresh start with total=1 completes with launched=retired=1.
- start held high through DONE -> stays DONE; drop start -> IDLE; start ignored while busy.
